// File: rtl/rgb_seq_pkg.sv
// Shared types and the default colour step table for rgb_pwm_sequencer.
package rgb_seq_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RAMP, HOLD} state_e;

  localparam int DEF_PWM_BITS  = 8;
  localparam int DEF_HOLD_BITS = 16;
  localparam int DEF_STEPS     = 6;

  // One colour step: target duties and hold length in ticks
  typedef struct packed {
    logic [DEF_PWM_BITS-1:0]  r;
    logic [DEF_PWM_BITS-1:0]  g;
    logic [DEF_PWM_BITS-1:0]  b;
    logic [DEF_HOLD_BITS-1:0] hold;
  } step_t;

  // Purple ramp, then yellow ramp; tables longer than this repeat it
  localparam step_t DEF_TABLE [DEF_STEPS] = '{
    '{8'd20,  8'd0,   8'd20,  16'd1000},
    '{8'd80,  8'd0,   8'd80,  16'd1000},
    '{8'd150, 8'd0,   8'd150, 16'd1000},
    '{8'd20,  8'd20,  8'd0,   16'd1000},
    '{8'd80,  8'd80,  8'd0,   16'd1000},
    '{8'd150, 8'd150, 8'd0,   16'd1000}
  };

  // Default entry for any table slot
  function automatic step_t default_step(input int idx);
    return DEF_TABLE[idx % DEF_STEPS];
  endfunction

endpackage

// File: rtl/rgb_seq_tick_gen.sv
// Ramp/hold tick prescaler: counts 0..TICK_DIV-1, tick high on the last count.
module rgb_seq_tick_gen #(
  parameter int TICK_DIV = 19200
) (
  input  logic CLK_IP,
  input  logic RST_IP,
  input  logic clr,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider; clr realigns the tick phase to sequence start
  always_ff @(posedge CLK_IP or posedge RST_IP) begin
    if (RST_IP)                 cnt <= '0;
    else if (clr || cnt == LAST) cnt <= '0;
    else                        cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// RGB LED colour sequencer: walks a step table, ramping the three PWM duties
// toward each entry one LSB per tick, holding, then advancing with wrap.
// Define RGB_SEQ_CFG_EN to make the step table writable through cfg_* ports.
module rgb_pwm_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int PWM_RESOLUTION_BITS = 8,
  parameter int NUM_STEPS           = 6,
  parameter int TICK_DIV            = 19200,
  parameter int HOLD_BITS           = 16,
  localparam int PW = PWM_RESOLUTION_BITS,
  localparam int SW = $clog2(NUM_STEPS)
) (
  input  logic                 CLK_IP,
  input  logic                 RST_IP,
  input  logic                 start_i,
  input  logic                 stop_i,
  output logic                 busy_o,
  output logic                 pwm_en_o,
  output logic [PW-1:0]        red_val_o,
  output logic [PW-1:0]        green_val_o,
  output logic [PW-1:0]        blue_val_o,
  output logic [SW-1:0]        step_idx_o,
  output logic                 wrap_o
`ifdef RGB_SEQ_CFG_EN
  ,
  input  logic                 cfg_we_i,
  input  logic [SW-1:0]        cfg_addr_i,
  input  logic [3*PW-1:0]      cfg_rgb_i,
  input  logic [HOLD_BITS-1:0] cfg_hold_i
`endif
);

  logic [PW-1:0]        tbl_r    [NUM_STEPS];
  logic [PW-1:0]        tbl_g    [NUM_STEPS];
  logic [PW-1:0]        tbl_b    [NUM_STEPS];
  logic [HOLD_BITS-1:0] tbl_hold [NUM_STEPS];

`ifdef RGB_SEQ_CFG_EN
  // Writable step table, reloaded with the default colours on reset
  always_ff @(posedge CLK_IP or posedge RST_IP) begin
    if (RST_IP) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        tbl_r[i]    <= PW'(DEF_TABLE[i % DEF_STEPS].r);
        tbl_g[i]    <= PW'(DEF_TABLE[i % DEF_STEPS].g);
        tbl_b[i]    <= PW'(DEF_TABLE[i % DEF_STEPS].b);
        tbl_hold[i] <= HOLD_BITS'(DEF_TABLE[i % DEF_STEPS].hold);
      end
    end else if (cfg_we_i && (int'(cfg_addr_i) < NUM_STEPS)) begin
      tbl_r[cfg_addr_i]    <= cfg_rgb_i[3*PW-1 -: PW];
      tbl_g[cfg_addr_i]    <= cfg_rgb_i[2*PW-1 -: PW];
      tbl_b[cfg_addr_i]    <= cfg_rgb_i[PW-1:0];
      tbl_hold[cfg_addr_i] <= cfg_hold_i;
    end
  end
`else
  // Fixed step table taken straight from the default constant
  for (genvar i = 0; i < NUM_STEPS; i++) begin : g_tbl
    localparam step_t E = default_step(i);
    assign tbl_r[i]    = PW'(E.r);
    assign tbl_g[i]    = PW'(E.g);
    assign tbl_b[i]    = PW'(E.b);
    assign tbl_hold[i] = HOLD_BITS'(E.hold);
  end
`endif

  state_e               state;
  logic [PW-1:0]        tgt_r, tgt_g, tgt_b;
  logic [HOLD_BITS-1:0] tgt_hold, hold_cnt;
  logic                 tick, start_go, at_tgt, last_step;

  assign start_go  = (state == IDLE) && start_i && !stop_i;
  assign at_tgt    = (red_val_o == tgt_r) && (green_val_o == tgt_g) && (blue_val_o == tgt_b);
  assign last_step = (step_idx_o == SW'(NUM_STEPS - 1));

  rgb_seq_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK_IP (CLK_IP),
    .RST_IP (RST_IP),
    .clr    (start_go),
    .tick   (tick)
  );

  // One LSB toward the target, never past it
  function automatic logic [PW-1:0] toward(input logic [PW-1:0] cur, input logic [PW-1:0] tgt);
    if (cur < tgt)      return cur + PW'(1);
    else if (cur > tgt) return cur - PW'(1);
    else                return cur;
  endfunction

  // Sequencer FSM; stop_i overrides everything and parks duties at zero
  always_ff @(posedge CLK_IP or posedge RST_IP) begin
    if (RST_IP) begin
      state       <= IDLE;
      busy_o      <= 1'b0;
      pwm_en_o    <= 1'b0;
      red_val_o   <= '0;
      green_val_o <= '0;
      blue_val_o  <= '0;
      step_idx_o  <= '0;
      wrap_o      <= 1'b0;
      tgt_r       <= '0;
      tgt_g       <= '0;
      tgt_b       <= '0;
      tgt_hold    <= '0;
      hold_cnt    <= '0;
    end else begin
      wrap_o <= 1'b0;
      if (stop_i) begin
        state       <= IDLE;
        busy_o      <= 1'b0;
        pwm_en_o    <= 1'b0;
        red_val_o   <= '0;
        green_val_o <= '0;
        blue_val_o  <= '0;
        step_idx_o  <= '0;
      end else begin
        case (state)
          IDLE: if (start_i) begin
            state      <= LOAD;
            busy_o     <= 1'b1;
            pwm_en_o   <= 1'b1;
            step_idx_o <= '0;
          end
          LOAD: begin
            tgt_r    <= tbl_r[step_idx_o];
            tgt_g    <= tbl_g[step_idx_o];
            tgt_b    <= tbl_b[step_idx_o];
            tgt_hold <= tbl_hold[step_idx_o];
            state    <= RAMP;
          end
          RAMP: begin
            // Exit as soon as all channels match; this does not wait for a tick
            if (at_tgt) begin
              state    <= HOLD;
              hold_cnt <= tgt_hold;
            end else if (tick) begin
              red_val_o   <= toward(red_val_o, tgt_r);
              green_val_o <= toward(green_val_o, tgt_g);
              blue_val_o  <= toward(blue_val_o, tgt_b);
            end
          end
          HOLD: if (tick) begin
            if (hold_cnt == '0) begin
              state <= LOAD;
              if (last_step) begin
                step_idx_o <= '0;
                wrap_o     <= 1'b1;
              end else begin
                step_idx_o <= step_idx_o + SW'(1);
              end
            end else begin
              hold_cnt <= hold_cnt - HOLD_BITS'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Self-checking bench for rgb_pwm_sequencer with TICK_DIV=4.
// Control vectors are table-driven; the long colour walk is checked through
// a scoreboard of expected output changes (values and spacing in cycles).
`timescale 1ns/1ps
module tb_rgb_pwm_sequencer;
  localparam int PW = 8, NS = 6, TD = 4, HB = 16, SW = 3;

  logic          CLK_IP = 1'b0;
  logic          RST_IP = 1'b1;
  logic          start_i = 1'b0, stop_i = 1'b0;
  logic          busy_o, pwm_en_o, wrap_o;
  logic [PW-1:0] red_val_o, green_val_o, blue_val_o;
  logic [SW-1:0] step_idx_o;
`ifdef RGB_SEQ_CFG_EN
  logic          cfg_we_i = 1'b0;
  logic [SW-1:0] cfg_addr_i = '0;
  logic [3*PW-1:0] cfg_rgb_i = '0;
  logic [HB-1:0] cfg_hold_i = '0;
`endif

  rgb_pwm_sequencer #(.PWM_RESOLUTION_BITS(PW), .NUM_STEPS(NS), .TICK_DIV(TD), .HOLD_BITS(HB)) dut (
    .CLK_IP(CLK_IP), .RST_IP(RST_IP), .start_i(start_i), .stop_i(stop_i),
    .busy_o(busy_o), .pwm_en_o(pwm_en_o), .red_val_o(red_val_o), .green_val_o(green_val_o),
    .blue_val_o(blue_val_o), .step_idx_o(step_idx_o), .wrap_o(wrap_o)
`ifdef RGB_SEQ_CFG_EN
    , .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_rgb_i(cfg_rgb_i), .cfg_hold_i(cfg_hold_i)
`endif
  );

  always #5 CLK_IP = ~CLK_IP;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected colour table (r/g/b/hold)
  int tr[NS] = '{20, 80, 150, 20, 80, 150};
  int tg[NS] = '{0, 0, 0, 20, 80, 150};
  int tb[NS] = '{20, 80, 150, 0, 0, 0};
  localparam int HOLD_DEF = 1000;

  // Scoreboard of output-change events
  typedef struct { int r; int g; int b; int idx; int gap; } snap_t;
  snap_t exp_q[$];
  int m_r, m_g, m_b, m_idx;

  function automatic int step1(input int c, input int t);
    if (c < t) return c + 1;
    if (c > t) return c - 1;
    return c;
  endfunction

  // Every ramp tick is TD cycles after the previous event
  task automatic add_ramp(input int r, input int g, input int b, input int max_ticks);
    int n = 0;
    while ((m_r != r || m_g != g || m_b != b) && n < max_ticks) begin
      m_r = step1(m_r, r); m_g = step1(m_g, g); m_b = step1(m_b, b);
      exp_q.push_back('{m_r, m_g, m_b, m_idx, TD});
      n++;
    end
  endtask

  // Index advances hold+1 ticks after the last duty change
  task automatic add_advance(input int hold);
    m_idx = (m_idx + 1) % NS;
    exp_q.push_back('{m_r, m_g, m_b, m_idx, TD * (hold + 1)});
  endtask

  task automatic model_reset();
    m_r = 0; m_g = 0; m_b = 0; m_idx = 0;
    exp_q.delete();
  endtask

  // Watch outputs each cycle; every change pops and checks one expected event
  task automatic run_sb(input int budget);
    snap_t e;
    int since = 0;
    int pr, pg, pb, pi;
    logic cw;
    pr = red_val_o; pg = green_val_o; pb = blue_val_o; pi = step_idx_o;
    for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
      @(posedge CLK_IP); #1;
      since++;
      cw = (pi == NS - 1) && (step_idx_o == 0);
      if (wrap_o || cw) chk("wrap_pulse", wrap_o, cw);
      if (red_val_o != pr || green_val_o != pg || blue_val_o != pb || step_idx_o != pi) begin
        e = exp_q.pop_front();
        chk("sb_red", red_val_o, e.r);
        chk("sb_green", green_val_o, e.g);
        chk("sb_blue", blue_val_o, e.b);
        chk("sb_idx", step_idx_o, e.idx);
        chk("sb_gap", since, e.gap);
        since = 0;
      end
      pr = red_val_o; pg = green_val_o; pb = blue_val_o; pi = step_idx_o;
    end
    if (exp_q.size() != 0) begin
      chk("sb_timeout_left", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Control vectors: one clock each, checked after the edge
  typedef struct { logic start; logic stop; logic busy; logic en; int idx; } vec_t;
  vec_t vecs[7];
  vec_t vq[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 0};  // start+stop in IDLE: stay
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 0};  // start -> LOAD
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 0};  // start ignored while busy
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 0};  // stop -> IDLE
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 0};

    // Reset values while RST_IP is held
    #2;
    chk("rst_busy", busy_o, 0);
    chk("rst_en", pwm_en_o, 0);
    chk("rst_red", red_val_o, 0);
    chk("rst_green", green_val_o, 0);
    chk("rst_blue", blue_val_o, 0);
    chk("rst_idx", step_idx_o, 0);
    chk("rst_wrap", wrap_o, 0);
    @(negedge CLK_IP); @(negedge CLK_IP);
    RST_IP = 1'b0;

    // Table-driven control vectors
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK_IP);
      start_i = vecs[i].start; stop_i = vecs[i].stop;
      vq.push_back(vecs[i]);
      @(posedge CLK_IP); #1;
      v = vq.pop_front();
      chk($sformatf("vec%0d_busy", i), busy_o, v.busy);
      chk($sformatf("vec%0d_en", i), pwm_en_o, v.en);
      chk($sformatf("vec%0d_red", i), red_val_o, 0);
      chk($sformatf("vec%0d_idx", i), step_idx_o, v.idx);
    end

    // Full walk through all six steps, wrap, and 10 ticks into step 0 again
    model_reset();
    add_ramp(tr[0], tg[0], tb[0], 1000);
    for (int s = 1; s < NS; s++) begin
      add_advance(HOLD_DEF);
      add_ramp(tr[s], tg[s], tb[s], 1000);
    end
    add_advance(HOLD_DEF);
    add_ramp(tr[0], tg[0], tb[0], 10);
    @(negedge CLK_IP);
    start_i = 1'b1;  // left high for the whole run: must be ignored
    @(posedge CLK_IP); #1;
    chk("start_busy", busy_o, 1);
    chk("start_en", pwm_en_o, 1);
    chk("start_red", red_val_o, 0);
    run_sb(40000);

    // Stop mid-ramp (start still high): IDLE, zeros, and stays there
    stop_i = 1'b1;
    @(posedge CLK_IP); #1;
    chk("stop_busy", busy_o, 0);
    chk("stop_en", pwm_en_o, 0);
    chk("stop_red", red_val_o, 0);
    chk("stop_green", green_val_o, 0);
    chk("stop_blue", blue_val_o, 0);
    chk("stop_idx", step_idx_o, 0);
    @(posedge CLK_IP); #1;
    chk("startstop_idle", busy_o, 0);
    stop_i = 1'b0; start_i = 1'b0;

    // Async reset in the middle of HOLD
    @(negedge CLK_IP); start_i = 1'b1;
    @(negedge CLK_IP); start_i = 1'b0;
    repeat (100) @(posedge CLK_IP);
    #1;
    chk("hold_red_pre", red_val_o, 20);
    chk("hold_busy_pre", busy_o, 1);
    #3 RST_IP = 1'b1;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_en", pwm_en_o, 0);
    chk("arst_red", red_val_o, 0);
    chk("arst_blue", blue_val_o, 0);
    chk("arst_idx", step_idx_o, 0);
    @(negedge CLK_IP); @(negedge CLK_IP);
    RST_IP = 1'b0;

`ifdef RGB_SEQ_CFG_EN
    // Entry 0 -> white with hold 0; a write to address 6 must not land anywhere
    @(negedge CLK_IP);
    cfg_we_i = 1'b1; cfg_addr_i = 3'd0; cfg_rgb_i = {8'd255, 8'd255, 8'd255}; cfg_hold_i = 16'd0;
    @(negedge CLK_IP);
    cfg_addr_i = 3'd6; cfg_rgb_i = {8'd1, 8'd2, 8'd3}; cfg_hold_i = 16'd5;
    @(negedge CLK_IP);
    cfg_we_i = 1'b0;
    model_reset();
    add_ramp(255, 255, 255, 1000);
    add_advance(0);
    add_ramp(tr[1], tg[1], tb[1], 8);
    start_i = 1'b1;
    @(posedge CLK_IP); #1;
    start_i = 1'b0;
    chk("cfg_start_busy", busy_o, 1);
    run_sb(3000);
    stop_i = 1'b1;
    @(posedge CLK_IP); #1;
    chk("cfg_stop_busy", busy_o, 0);
    stop_i = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
